// File: rtl/spi_transmit_if.sv
// Bundles the user start/done handshake and the shared DAC serial lines of the
// dual-channel SPI transmitter.
interface spi_transmit_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              start;
    logic              done;
    logic              busy;
    logic              sdata1;
    logic              sdata2;
    logic              sclk;
    logic              ncs;

    modport master (
        output data1, data2, start,
        input  done, busy, sdata1, sdata2, sclk, ncs
    );

    modport slave (
        input  data1, data2, start,
        output done, busy, sdata1, sdata2, sclk, ncs
    );
endinterface

// File: rtl/spi_transmit.sv
// Dual-channel SPI transmitter for a pair of 12-bit DACs: two {2'b00,PD_MODE,data}
// frames shifted MSB first on a shared sclk (idle high) and active-low ncs.
module spi_transmit #(
    parameter int         CLK_DIV = 2,
    parameter int         DATA_W  = 12,
    parameter logic [1:0] PD_MODE = 2'b00
) (
    input logic           i_clk,
    input logic           i_rst,
    spi_transmit_if.slave bus
);
    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_END
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit;
    logic [FRAME_W-1:0] r_shift1;
    logic [FRAME_W-1:0] r_shift2;
    logic               r_sdata1;
    logic               r_sdata2;
    logic               r_sclk;
    logic               r_ncs;
    logic               r_busy;
    logic               r_done;

    state_t             w_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [BIT_W-1:0]   w_bit;
    logic [FRAME_W-1:0] w_shift1;
    logic [FRAME_W-1:0] w_shift2;
    logic               w_sdata1;
    logic               w_sdata2;
    logic               w_sclk;
    logic               w_ncs;
    logic               w_busy;
    logic               w_done;

    logic [FRAME_W-1:0] w_frame1;
    logic [FRAME_W-1:0] w_frame2;
    logic               w_halfDone;

    assign w_frame1   = {2'b00, PD_MODE, bus.data1};
    assign w_frame2   = {2'b00, PD_MODE, bus.data2};
    assign w_halfDone = (r_cnt == HALF_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift1 <= '0;
            r_shift2 <= '0;
            r_sdata1 <= 1'b0;
            r_sdata2 <= 1'b0;
            r_sclk   <= 1'b1;
            r_ncs    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift1 <= w_shift1;
            r_shift2 <= w_shift2;
            r_sdata1 <= w_sdata1;
            r_sdata2 <= w_sdata2;
            r_sclk   <= w_sclk;
            r_ncs    <= w_ncs;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Data moves only on sclk rising edges, so it is stable CLK_DIV cycles around each falling edge.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_shift1 = r_shift1;
        w_shift2 = r_shift2;
        w_sdata1 = r_sdata1;
        w_sdata2 = r_sdata2;
        w_sclk   = r_sclk;
        w_ncs    = r_ncs;
        w_busy   = r_busy;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state  = S_SHIFT;
                    w_shift1 = w_frame1;
                    w_shift2 = w_frame2;
                    w_sdata1 = w_frame1[FRAME_W-1];
                    w_sdata2 = w_frame2[FRAME_W-1];
                    w_sclk   = 1'b1;
                    w_ncs    = 1'b0;
                    w_busy   = 1'b1;
                    w_cnt    = '0;
                    w_bit    = '0;
                end
            end
            S_SHIFT: begin
                if (!w_halfDone) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt = '0;
                    if (r_sclk) begin
                        w_sclk = 1'b0;
                    end else if (r_bit == BIT_LAST) begin
                        w_state  = S_END;
                        w_sclk   = 1'b1;
                        w_ncs    = 1'b1;
                        w_sdata1 = 1'b0;
                        w_sdata2 = 1'b0;
                    end else begin
                        w_sclk   = 1'b1;
                        w_shift1 = r_shift1 << 1;
                        w_shift2 = r_shift2 << 1;
                        w_sdata1 = r_shift1[FRAME_W-2];
                        w_sdata2 = r_shift2[FRAME_W-2];
                        w_bit    = r_bit + 1'b1;
                    end
                end
            end
            S_END: begin
                if (!w_halfDone) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt   = '0;
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.sdata1 = r_sdata1;
    assign bus.sdata2 = r_sdata2;
    assign bus.sclk   = r_sclk;
    assign bus.ncs    = r_ncs;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
